// File: rtl/dm_responder_if.sv
// Load/store port between core and data-memory responder.
// Request and response channels, each with a valid/ready pair.
interface dm_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_wr;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_wr, req_addr,
    output req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_wr, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr,
    input  req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_wr, rsp_rdata
  );
endinterface

// File: rtl/dm_responder.sv
// Handshaked multi-cycle data memory: one request outstanding,
// configurable access latency, byte-enabled writes.
module dm_responder #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  dm_responder_if.slave   bus,
  output logic            busy
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  if (LATENCY < 0 || LATENCY > 15) begin : g_lat_chk
    $error("dm_responder: LATENCY must be 0..15");
  end
  if (DATA_W != 32) begin : g_dw_chk
    $error("dm_responder: DATA_W must be 32");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [3:0]        cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic              rsp_wr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic accept;
  logic access;

  assign accept = (state == IDLE) && bus.req_valid;
  assign access = (state == WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.req_valid) state_nx = WAIT;
      WAIT:    if (cnt == 4'd0)   state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    busy          = 1'b1;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
      end
      RESP:    bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rsp_wr_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        cnt     <= LAT;
        wr_q    <= bus.req_wr;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        rsp_wr_q <= wr_q;
        rdata_q  <= wr_q ? '0 : mem[addr_q];
      end
    end
  end

  // Array is not reset; async reset already forces state out of WAIT
  always_ff @(posedge clk) begin
    if (access && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.rsp_wr    = rsp_wr_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder at LATENCY 0, 2 and 4.
// Expected responses are queued at issue and popped by monitors.
module tb_dm_responder;

  logic clk = 1'b0;
  logic rst0, rst2, rst4;
  logic bsy0, bsy2, bsy4;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [32:0] q0[$];
  logic [32:0] q2[$];
  logic [32:0] q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dm_responder_if b0 ();
  dm_responder_if b2 ();
  dm_responder_if b4 ();

  dm_responder #(.LATENCY(0)) u0 (
    .clk(clk), .rst(rst0), .bus(b0), .busy(bsy0)
  );
  dm_responder #(.LATENCY(2)) u2 (
    .clk(clk), .rst(rst2), .bus(b2), .busy(bsy2)
  );
  dm_responder #(.LATENCY(4)) u4 (
    .clk(clk), .rst(rst4), .bus(b4), .busy(bsy4)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic sb(int k, ref logic [32:0] q[$], input logic w,
                    input logic [31:0] d);
    logic [32:0] e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL sb%0d: unexpected rsp wr=%0b data=%h", k, w, d);
    end else begin
      e = q.pop_front();
      if ({w, d} !== e) begin
        errors++;
        $display("FAIL sb%0d: got wr=%0b data=%h want wr=%0b data=%h",
                 k, w, d, e[32], e[31:0]);
      end
    end
  endtask

  always @(negedge clk)
    if (b0.rsp_valid && b0.rsp_ready) sb(0, q0, b0.rsp_wr, b0.rsp_rdata);
  always @(negedge clk)
    if (b2.rsp_valid && b2.rsp_ready) sb(2, q2, b2.rsp_wr, b2.rsp_rdata);
  always @(negedge clk)
    if (b4.rsp_valid && b4.rsp_ready) sb(4, q4, b4.rsp_wr, b4.rsp_rdata);

  task automatic push(int k, logic [32:0] e);
    case (k)
      0:       q0.push_back(e);
      2:       q2.push_back(e);
      default: q4.push_back(e);
    endcase
  endtask

  function automatic int qsz(int k);
    case (k)
      0:       return q0.size();
      2:       return q2.size();
      default: return q4.size();
    endcase
  endfunction

  task automatic drv(int k, logic v, logic w, logic [9:0] a,
                     logic [31:0] d, logic [3:0] be);
    case (k)
      0: begin
        b0.req_valid = v; b0.req_wr = w; b0.req_addr = a;
        b0.req_wdata = d; b0.req_be = be;
      end
      2: begin
        b2.req_valid = v; b2.req_wr = w; b2.req_addr = a;
        b2.req_wdata = d; b2.req_be = be;
      end
      default: begin
        b4.req_valid = v; b4.req_wr = w; b4.req_addr = a;
        b4.req_wdata = d; b4.req_be = be;
      end
    endcase
  endtask

  // {req_ready, rsp_valid, rsp_wr, busy, rsp_rdata}
  function automatic logic [35:0] obs(int k);
    case (k)
      0: return {b0.req_ready, b0.rsp_valid, b0.rsp_wr, bsy0,
                 b0.rsp_rdata};
      2: return {b2.req_ready, b2.rsp_valid, b2.rsp_wr, bsy2,
                 b2.rsp_rdata};
      default: return {b4.req_ready, b4.rsp_valid, b4.rsp_wr, bsy4,
                       b4.rsp_rdata};
    endcase
  endfunction

  task automatic chk_idle(string nm, int k);
    logic [35:0] o;
    o = obs(k);
    chk({nm, ".req_ready"}, 32'(o[35]), 32'd1);
    chk({nm, ".rsp_valid"}, 32'(o[34]), 32'd0);
    chk({nm, ".rsp_wr"}, 32'(o[33]), 32'd0);
    chk({nm, ".busy"}, 32'(o[32]), 32'd0);
    chk({nm, ".rsp_rdata"}, o[31:0], 32'd0);
  endtask

  task automatic req(int k, logic w, logic [9:0] a, logic [31:0] d,
                     logic [3:0] be, logic [31:0] exp, bit pu,
                     output int acc);
    logic r;
    bit   ok;
    ok  = 1'b0;
    acc = -1;
    drv(k, 1'b1, w, a, d, be);
    if (pu) push(k, {w, w ? 32'h0 : exp});
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      r = obs(k)[35];
      @(posedge clk);
      #1;
      if (r) begin
        ok  = 1'b1;
        acc = cyc;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept%0d: got timeout want accept", k);
    end
  endtask

  task automatic idle(int k);
    drv(k, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0);
  endtask

  task automatic wait_rsp(int k, output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (obs(k)[34]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic drain(int k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (qsz(k) == 0 && !obs(k)[32]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain%0d: got pending=%0d want 0", k, qsz(k));
    end
  endtask

  task automatic xact(int k, logic w, logic [9:0] a, logic [31:0] d,
                      logic [3:0] be, logic [31:0] exp);
    int acc;
    req(k, w, a, d, be, exp, 1'b1, acc);
    idle(k);
    drain(k);
  endtask

  initial begin
    int acc;
    int n;
    int h;
    int at[8];
    rst0 = 1'b0;
    rst2 = 1'b0;
    rst4 = 1'b0;
    b0.rsp_ready = 1'b1;
    b2.rsp_ready = 1'b1;
    b4.rsp_ready = 1'b1;
    idle(0);
    idle(2);
    idle(4);

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_idle("in_reset", 2);
    end
    rst0 = 1'b1;
    rst2 = 1'b1;
    rst4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_idle("after_reset", 2);
    end

    req(2, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 32'h0, 1'b1, acc);
    idle(2);
    wait_rsp(2, n);
    chk("lat2_rsp_delay", 32'(n), 32'd3);
    drain(2);
    xact(2, 1'b0, 10'h005, 32'h0, 4'h0, 32'hDEADBEEF);

    xact(2, 1'b1, 10'h3FF, 32'h11223344, 4'hF, 32'h0);
    xact(2, 1'b1, 10'h3FF, 32'hAABBCCDD, 4'b0101, 32'h0);
    xact(2, 1'b1, 10'h3FF, 32'hFFFFFFFF, 4'h0, 32'h0);
    xact(2, 1'b0, 10'h3FF, 32'h0, 4'h0, 32'h11BB33DD);

    for (int i = 0; i < 4; i++)
      req(0, 1'b1, 10'(i), 32'hA000_0000 + 32'(i), 4'hF, 32'h0,
          1'b1, at[i]);
    for (int i = 0; i < 4; i++)
      req(0, 1'b0, 10'(i), 32'h0, 4'h0, 32'hA000_0000 + 32'(i),
          1'b1, at[i+4]);
    idle(0);
    drain(0);
    for (int i = 1; i < 8; i++)
      chk("b2b_spacing", 32'(at[i] - at[i-1]), 32'd3);

    b0.rsp_ready = 1'b0;
    req(0, 1'b0, 10'd2, 32'h0, 4'h0, 32'hA000_0002, 1'b1, acc);
    drv(0, 1'b1, 1'b0, 10'd1, 32'h0, 4'h0);
    wait_rsp(0, n);
    chk("lat0_rsp_delay", 32'(n), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp.rsp_valid", 32'(obs(0)[34]), 32'd1);
      chk("bp.rsp_wr", 32'(obs(0)[33]), 32'd0);
      chk("bp.rsp_rdata", obs(0)[31:0], 32'hA000_0002);
      chk("bp.req_ready", 32'(obs(0)[35]), 32'd0);
    end
    b0.rsp_ready = 1'b1;
    h = cyc + 1;
    req(0, 1'b0, 10'd1, 32'h0, 4'h0, 32'hA000_0001, 1'b1, acc);
    idle(0);
    chk("bp_second_accept", 32'(acc), 32'(h + 1));
    drain(0);

    req(4, 1'b1, 10'h010, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1, acc);
    idle(4);
    wait_rsp(4, n);
    chk("lat4_rsp_delay", 32'(n), 32'd5);
    drain(4);
    req(4, 1'b1, 10'h010, 32'h12345678, 4'hF, 32'h0, 1'b0, acc);
    idle(4);
    repeat (2) @(posedge clk);
    #1;
    rst4 = 1'b0;
    #1;
    chk_idle("mid_reset", 4);
    @(posedge clk);
    #1;
    rst4 = 1'b1;
    xact(4, 1'b0, 10'h010, 32'h0, 4'h0, 32'hCAFEF00D);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q2_empty", 32'(q2.size()), 32'd0);
    chk("q4_empty", 32'(q4.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
